bp_me_lce_req_arbiter: RTL and testbench
========================================

# bp_me_lce_req_arbiter

Round-robin arbiter that shares one CCE request input among `num_lce_p` LCE request channels (I$ and D$ of every core). It sits between the per-core `lce_cce_req` outputs and a single-ported CCE request port in the memory-end top. Each requester gets a small input buffer, and the output is registered with a valid/yumi handshake. The block tags every granted request with the source LCE id.

## Interface
- `num_lce_p`, no default ("inv"), number of requesting LCEs; must be ≥ 2.
- `req_width_p`, no default ("inv"), width of one `bp_lce_cce_req_s`.
- `buf_els_p`, default 2, depth of each per-LCE input buffer; must be ≥ 2.
- `lce_id_width_lp`, localparam, `BSG_SAFE_CLOG2(num_lce_p)`.

Ports:
- `clk_i`, in, 1, the single clock.
- `reset_n_i`, in, 1, synchronous active-low reset.
- `lce_req_i`, in, `[num_lce_p-1:0][req_width_p-1:0]`, request payload per LCE.
- `lce_req_v_i`, in, `num_lce_p`, valid per LCE.
- `lce_req_ready_o`, out, `num_lce_p`, ready per LCE. Handshake is ready-then-valid.
- `cce_req_o`, out, `req_width_p`, granted payload (registered).
- `cce_req_lce_id_o`, out, `lce_id_width_lp`, source LCE of `cce_req_o`.
- `cce_req_v_o`, out, 1, output valid.
- `cce_req_yumi_i`, in, 1, consumer accepts the output this cycle; legal only when `cce_req_v_o`=1.

## Operation
- **Input buffers.** Per LCE i, a `buf_els_p`-deep FIFO is written when `lce_req_v_i[i] & lce_req_ready_o[i]`. `lce_req_ready_o[i]` equals "FIFO i not full". Valid asserted without ready is ignored: no write, no error.
- **Output register.** Holds payload and LCE id. It is "free" when `!cce_req_v_o | cce_req_yumi_i`.
- **Arbitration.** Each cycle the output is free and at least one FIFO is non-empty:
  - Grant the first non-empty FIFO scanning from `rr_ptr` upward, modulo `num_lce_p`.
  - Pop that FIFO and load its head into the output register at the clock edge.
  - Set `rr_ptr` to grant+1, wrapping `num_lce_p-1` to 0.
- **No grant.** If the output is not free or all FIFOs are empty, nothing pops and `rr_ptr` holds.
- **Empty on consume.** If `cce_req_yumi_i`=1 and no FIFO is non-empty, `cce_req_v_o` falls next cycle.
- **Priority.** The pointer is round-robin with last-grant-lowest priority, so no requester starves. Worst-case wait for a FIFO head is `num_lce_p-1` grants.
- **Pointer arithmetic.** `rr_ptr` is `lce_id_width_lp` wide. Wrap is explicit, not a power-of-two overflow, so it is correct for non-power-of-2 `num_lce_p`.
- **Simultaneous push and pop on one FIFO.** Both are allowed. A full FIFO is not ready that cycle, even if it is popped in the same cycle: ready is not combinationally dependent on the pop.

## Timing
- **Reset values** while `reset_n_i`=0:
  - `lce_req_ready_o` = 0
  - `cce_req_v_o` = 0
  - `cce_req_o` and `cce_req_lce_id_o` = 0
  - `rr_ptr` = 0
  - all FIFOs empty
- **First cycle after reset.** `lce_req_ready_o` = all ones.
- **Reset mid-operation.** All buffered and registered requests are discarded. Nothing is emitted after reset deasserts.
- **Latency.** A request accepted at edge t appears on `cce_req_v_o` at t+2 at the earliest: FIFO write at t, output load at t+1.
- **Throughput.** One request per cycle when `cce_req_yumi_i` is held high.
- **Output stability.** While `cce_req_v_o`=1 and `cce_req_yumi_i`=0, `cce_req_o` and `cce_req_lce_id_o` hold stable.
- **Combinational paths.** None from any input to any output. `cce_req_yumi_i` affects only next-state logic.

## Structure
- Shared package (`bp_common_pkg`) holds no new typedefs; payload is opaque `req_width_p` bits.
- The round-robin scan is a sub-module `bp_me_rr_arb`: inputs `reqs_i`, `ptr_i`; outputs `grant_one_hot_o`, `grant_id_o`, `v_o`. Purely combinational, reused for resp/data-resp channels.
- Input buffers reuse `bsg_fifo_1r1w_small` with `ready_THEN_valid_p(1)`. The reset to the FIFOs is `~reset_n_i`.
- The top holds `rr_ptr`, the output register, and the FIFO pop logic.

## Test plan
- **Single request.** `num_lce_p`=4. LCE2 sends A at cycle 5, `cce_req_yumi_i`=1 → `cce_req_v_o`=1 at cycle 7 with payload A and id 2; `v_o`=0 at cycle 8.
- **All simultaneous.** All 4 LCEs send one request each at cycle 5 from reset pointer 0, yumi always high → ids 0,1,2,3 on cycles 7,8,9,10.
- **Fairness and wrap.** LCE0 and LCE3 continuously valid, `num_lce_p`=4 → grants alternate 0,3,0,3. `rr_ptr` wraps 3→0 with no duplicate grant.
- **Backpressure and full.** yumi=0 for 10 cycles while LCE1 pushes every cycle → `lce_req_ready_o[1]` drops after 2 accepted entries (`buf_els_p`=2) plus 1 in the output register. Output holds stable. After yumi=1, the 3 entries drain in order.
- **Reset mid-operation.** 3 requests buffered, `reset_n_i`=0 for 1 cycle → `v_o`=0 and ready=0 during reset, ready=all ones after, no stale output.
- **Non-power-of-2.** `num_lce_p`=3, all valid → ids cycle 0,1,2,0. An id of 3 never appears.

Source files
------------

// File: rtl/bp_me_lce_req_arbiter_pkg.sv
// bp_me_lce_req_arbiter_pkg: shared helpers for the LCE request arbiter slice
package bp_me_lce_req_arbiter_pkg;
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  // Explicit wrap so non-power-of-2 counts never rely on overflow.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction
endpackage

// File: rtl/bp_me_rr_arb.sv
// bp_me_rr_arb: combinational round-robin scan starting at ptr_i
// Ports: reqs_i requesters, ptr_i scan start; grant_one_hot_o / grant_id_o winner, v_o any grant.
module bp_me_rr_arb
  import bp_me_lce_req_arbiter_pkg::*;
#(
  parameter int num_lce_p = 4,
  localparam int id_w = safe_clog2(num_lce_p)
) (
  input  logic [num_lce_p-1:0] reqs_i,
  input  logic [id_w-1:0]      ptr_i,
  output logic [num_lce_p-1:0] grant_one_hot_o,
  output logic [id_w-1:0]      grant_id_o,
  output logic                 v_o
);
  logic [id_w-1:0] idx;
  // Scanning backwards lets the closest requester to ptr_i win by being written last.
  always_comb begin
    grant_one_hot_o = '0;
    grant_id_o = '0;
    v_o = 1'b0;
    idx = '0;
    for (int k = num_lce_p - 1; k >= 0; k--) begin
      idx = id_w'((int'(ptr_i) + k) % num_lce_p);
      if (reqs_i[idx]) begin
        grant_id_o = idx;
        v_o = 1'b1;
      end
    end
    if (v_o) grant_one_hot_o[grant_id_o] = 1'b1;
  end
endmodule

// File: rtl/bp_me_lce_req_arbiter.sv
// bp_me_lce_req_arbiter: buffers LCE requests and round-robins them onto one registered CCE port
// Ports: clk_i, reset_n_i (sync, active-low); lce_req_i/_v_i/_ready_o per-LCE ready-then-valid inputs;
// cce_req_o/_lce_id_o/_v_o registered output with cce_req_yumi_i consume strobe.
module bp_me_lce_req_arbiter
  import bp_me_lce_req_arbiter_pkg::*;
#(
  parameter int num_lce_p = 4,
  parameter int req_width_p = 16,
  parameter int buf_els_p = 2,
  localparam int lce_id_width_lp = safe_clog2(num_lce_p)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_lce_p-1:0][req_width_p-1:0] lce_req_i,
  input  logic [num_lce_p-1:0]                  lce_req_v_i,
  output logic [num_lce_p-1:0]                  lce_req_ready_o,
  output logic [req_width_p-1:0]                cce_req_o,
  output logic [lce_id_width_lp-1:0]            cce_req_lce_id_o,
  output logic                                  cce_req_v_o,
  input  logic                                  cce_req_yumi_i
);
  localparam int ptr_w = safe_clog2(buf_els_p);
  localparam int cnt_w = $clog2(buf_els_p + 1);
  logic [req_width_p-1:0] mem [num_lce_p][buf_els_p];
  logic [req_width_p-1:0] head [num_lce_p];
  logic [ptr_w-1:0] wptr [num_lce_p];
  logic [ptr_w-1:0] rptr [num_lce_p];
  logic [cnt_w-1:0] cnt [num_lce_p];
  logic [num_lce_p-1:0] nonempty, full, push, pop, grant_oh;
  logic [lce_id_width_lp-1:0] grant_id, rr_ptr;
  logic grant_v, out_free, ready_en;
  assign out_free = ~cce_req_v_o | cce_req_yumi_i;
  for (genvar i = 0; i < num_lce_p; i++) begin : g_lce
    assign nonempty[i] = cnt[i] != '0;
    assign full[i] = cnt[i] == cnt_w'(buf_els_p);
    // Ready comes only from registered state, never from this cycle's pop.
    assign lce_req_ready_o[i] = ready_en & ~full[i];
    assign push[i] = lce_req_v_i[i] & lce_req_ready_o[i];
    assign pop[i] = grant_oh[i] & out_free;
    assign head[i] = mem[i][rptr[i]];
  end
  bp_me_rr_arb #(.num_lce_p(num_lce_p)) arb (
    .reqs_i(nonempty),
    .ptr_i(rr_ptr),
    .grant_one_hot_o(grant_oh),
    .grant_id_o(grant_id),
    .v_o(grant_v)
  );
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_lce_p; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < num_lce_p; i++) begin
        if (push[i]) begin
          mem[i][wptr[i]] <= lce_req_i[i];
          wptr[i] <= (wptr[i] == ptr_w'(buf_els_p - 1)) ? '0 : wptr[i] + 1'b1;
        end
        if (pop[i]) rptr[i] <= (rptr[i] == ptr_w'(buf_els_p - 1)) ? '0 : rptr[i] + 1'b1;
        cnt[i] <= cnt[i] + cnt_w'(push[i]) - cnt_w'(pop[i]);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      ready_en <= 1'b0;
      cce_req_v_o <= 1'b0;
      cce_req_o <= '0;
      cce_req_lce_id_o <= '0;
      rr_ptr <= '0;
    end else begin
      ready_en <= 1'b1;
      if (out_free) begin
        cce_req_v_o <= grant_v;
        if (grant_v) begin
          cce_req_o <= head[grant_id];
          cce_req_lce_id_o <= grant_id;
          rr_ptr <= lce_id_width_lp'(wrap_inc(int'(grant_id), num_lce_p));
        end
      end
    end
  end
endmodule

// File: tb/tb_bp_me_lce_req_arbiter.sv
// tb_bp_me_lce_req_arbiter: vector table, directed corner sequences and a queue-model random run
module tb_bp_me_lce_req_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, yumi = 1'b0, ov;
  logic [3:0][7:0] req = '0;
  logic [3:0] v = '0, rdy;
  logic [7:0] od;
  logic [1:0] oid;
  logic rst3_n = 1'b0, yumi3 = 1'b0, ov3;
  logic [2:0][7:0] req3 = '0;
  logic [2:0] v3 = '0, rdy3;
  logic [7:0] od3;
  logic [1:0] oid3;
  int errors = 0, checks = 0;
  bp_me_lce_req_arbiter #(.num_lce_p(4), .req_width_p(8), .buf_els_p(2)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .lce_req_i(req), .lce_req_v_i(v), .lce_req_ready_o(rdy),
    .cce_req_o(od), .cce_req_lce_id_o(oid), .cce_req_v_o(ov), .cce_req_yumi_i(yumi)
  );
  bp_me_lce_req_arbiter #(.num_lce_p(3), .req_width_p(8), .buf_els_p(2)) dut3 (
    .clk_i(clk), .reset_n_i(rst3_n), .lce_req_i(req3), .lce_req_v_i(v3), .lce_req_ready_o(rdy3),
    .cce_req_o(od3), .cce_req_lce_id_o(oid3), .cce_req_v_o(ov3), .cce_req_yumi_i(yumi3)
  );
  typedef struct {
    logic r; logic [3:0] v; logic [31:0] d; logic y;
    logic [3:0] er; logic ev; logic [7:0] ed; logic [1:0] eid;
  } vec_t;
  vec_t tbl [13];
  function automatic vec_t mk(input logic r, input logic [3:0] vv, input logic [31:0] d, input logic y,
                              input logic [3:0] er, input logic ev, input logic [7:0] ed, input logic [1:0] eid);
    vec_t t;
    t.r = r; t.v = vv; t.d = d; t.y = y; t.er = er; t.ev = ev; t.ed = ed; t.eid = eid;
    return t;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0; v = '0; yumi = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  logic [7:0] mq [4][$];
  int mptr;
  bit mov, men;
  logic [7:0] mod;
  int moid;
  task automatic model_step(input logic r, input logic [3:0] vi, input logic [31:0] di, input logic y);
    logic [3:0] rdy_m;
    bit free;
    int g;
    if (!r) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      mptr = 0; mov = 0; men = 0;
    end else begin
      for (int i = 0; i < 4; i++) rdy_m[i] = men && mq[i].size() < 2;
      free = !mov || y;
      g = -1;
      if (free) begin
        for (int k = 0; k < 4; k++) if (g < 0 && mq[(mptr + k) % 4].size() > 0) g = (mptr + k) % 4;
        mov = g >= 0;
        if (g >= 0) begin
          mod = mq[g].pop_front();
          moid = g;
          mptr = (g + 1) % 4;
        end
      end
      for (int i = 0; i < 4; i++) if (vi[i] && rdy_m[i]) mq[i].push_back(di[i*8 +: 8]);
      men = 1;
    end
  endtask
  initial begin
    int acc;
    int ids [$];
    logic [3:0] exp_rdy;
    tbl[0]  = mk(0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 2'd0);
    tbl[1]  = mk(1, 4'h0, 32'h0, 0, 4'hF, 0, 8'h00, 2'd0);
    tbl[2]  = mk(1, 4'b0100, 32'h00A5_0000, 0, 4'hF, 0, 8'h00, 2'd0);
    tbl[3]  = mk(1, 4'h0, 32'h0, 0, 4'hF, 1, 8'hA5, 2'd2);
    tbl[4]  = mk(1, 4'h0, 32'h0, 1, 4'hF, 0, 8'h00, 2'd0);
    tbl[5]  = mk(0, 4'h0, 32'h0, 0, 4'h0, 0, 8'h00, 2'd0);
    tbl[6]  = mk(1, 4'h0, 32'h0, 0, 4'hF, 0, 8'h00, 2'd0);
    tbl[7]  = mk(1, 4'hF, 32'h1312_1110, 0, 4'hF, 0, 8'h00, 2'd0);
    tbl[8]  = mk(1, 4'h0, 32'h0, 0, 4'hF, 1, 8'h10, 2'd0);
    tbl[9]  = mk(1, 4'h0, 32'h0, 1, 4'hF, 1, 8'h11, 2'd1);
    tbl[10] = mk(1, 4'h0, 32'h0, 1, 4'hF, 1, 8'h12, 2'd2);
    tbl[11] = mk(1, 4'h0, 32'h0, 1, 4'hF, 1, 8'h13, 2'd3);
    tbl[12] = mk(1, 4'h0, 32'h0, 1, 4'hF, 0, 8'h00, 2'd0);
    for (int n = 0; n < 13; n++) begin
      rst_n = tbl[n].r; v = tbl[n].v; req = tbl[n].d; yumi = tbl[n].y;
      tick();
      chk($sformatf("vec%0d_ready", n), 32'(rdy), 32'(tbl[n].er));
      chk($sformatf("vec%0d_v", n), 32'(ov), 32'(tbl[n].ev));
      if (tbl[n].ev) begin
        chk($sformatf("vec%0d_data", n), 32'(od), 32'(tbl[n].ed));
        chk($sformatf("vec%0d_id", n), 32'(oid), 32'(tbl[n].eid));
      end
      if (!tbl[n].r) begin
        chk($sformatf("vec%0d_rst_data", n), 32'(od), 32'h0);
        chk($sformatf("vec%0d_rst_id", n), 32'(oid), 32'h0);
      end
    end
    do_reset();
    v = 4'b1001; req = 32'h3300_0030;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (ov) ids.push_back(int'(oid));
      yumi = ov;
    end
    v = '0; yumi = 1'b0;
    chk("wrap_count_ge8", 32'(ids.size() >= 8), 32'd1);
    for (int k = 0; k < 8 && k < ids.size(); k++) chk($sformatf("wrap_id%0d", k), 32'(ids[k]), (k % 2 == 0) ? 32'd0 : 32'd3);
    do_reset();
    v = 4'b0010; yumi = 1'b0; acc = 0;
    for (int k = 0; k < 10; k++) begin
      bit took;
      req[1] = 8'(32'h20 + acc);
      took = rdy[1];
      tick();
      if (took) acc++;
      if (k >= 1) begin
        chk($sformatf("bp_hold_v%0d", k), 32'(ov), 32'd1);
        chk($sformatf("bp_hold_data%0d", k), 32'(od), 32'h20);
      end
    end
    chk("bp_accepted", 32'(acc), 32'd3);
    chk("bp_ready_low", 32'(rdy[1]), 32'd0);
    chk("bp_id", 32'(oid), 32'd1);
    v = '0; yumi = 1'b1;
    tick();
    chk("drain1_v", 32'(ov), 32'd1);
    chk("drain1_data", 32'(od), 32'h21);
    chk("drain1_ready", 32'(rdy[1]), 32'd1);
    tick();
    chk("drain2_v", 32'(ov), 32'd1);
    chk("drain2_data", 32'(od), 32'h22);
    tick();
    chk("drain3_v", 32'(ov), 32'd0);
    yumi = 1'b0;
    do_reset();
    v = 4'b0111; req = 32'h0042_4140;
    tick();
    v = '0;
    tick();
    chk("mid_pre_v", 32'(ov), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_ready", 32'(rdy), 32'h0);
    chk("mid_rst_v", 32'(ov), 32'd0);
    chk("mid_rst_data", 32'(od), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("mid_after_ready", 32'(rdy), 32'hF);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("mid_no_stale%0d", k), 32'(ov), 32'd0);
      tick();
    end
    rst3_n = 1'b0;
    tick();
    rst3_n = 1'b1;
    tick();
    chk("np2_ready", 32'(rdy3), 32'h7);
    ids.delete();
    v3 = 3'b111; req3 = 24'h52_5150;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ov3) ids.push_back(int'(oid3));
      yumi3 = ov3;
    end
    v3 = '0; yumi3 = 1'b0;
    chk("np2_count_ge6", 32'(ids.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < ids.size(); k++) chk($sformatf("np2_id%0d", k), 32'(ids[k]), 32'(k % 3));
    foreach (ids[k]) if (ids[k] > 2) chk("np2_id_range", 32'(ids[k]), 32'd2);
    for (int c = 0; c < 400; c++) begin
      logic r;
      r = (c == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      rst_n = r;
      v = 4'($urandom);
      req = $urandom;
      yumi = mov ? ($urandom_range(0, 2) != 0) : 1'b0;
      model_step(r, v, req, yumi);
      tick();
      for (int i = 0; i < 4; i++) exp_rdy[i] = men && mq[i].size() < 2;
      chk("rand_ready", 32'(rdy), 32'(exp_rdy));
      chk("rand_v", 32'(ov), 32'(mov));
      if (mov) begin
        chk("rand_data", 32'(od), 32'(mod));
        chk("rand_id", 32'(oid), 32'(moid));
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
